// File: rtl/dma_engine.sv
// -----------------------------------------------------------------------------
// dma_engine
//   Single-channel word-copy DMA sharing one data bus with a CPU. The CPU
//   programs SRC/DST/LEN and then writes CTRL to start. The engine moves one
//   32-bit word at a time with a read / capture / write sequence, and it only
//   takes bus cycles in which the CPU is not driving the bus.
//
// Parameters
//   LEN_W        width of the transfer-length and remaining-count fields (words)
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   reg_addr     register select: 0 SRC, 1 DST, 2 LEN, 3 CTRL/STATUS
//   reg_wdata    register write data
//   reg_wenable  register write strobe (one cycle per write)
//   reg_rdata    combinational read data for reg_addr
//   cpu_busy     CPU owns the shared bus this cycle
//   m_req        DMA owns the shared bus this cycle
//   m_addr       bus byte address (valid while m_req=1)
//   m_wdata      bus write data
//   m_wenable    bus byte enables, 4'hF on a write, 4'h0 otherwise
//   m_rdata      bus read data, valid one cycle after a read request
//   irq          one-cycle completion pulse, gated by irq_en
// -----------------------------------------------------------------------------
module dma_engine #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       reg_addr,
    input  logic [31:0]      reg_wdata,
    input  logic             reg_wenable,
    output logic [31:0]      reg_rdata,
    input  logic             cpu_busy,
    output logic             m_req,
    output logic [31:0]      m_addr,
    output logic [31:0]      m_wdata,
    output logic [3:0]       m_wenable,
    input  logic [31:0]      m_rdata,
    output logic             irq
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [31:0]      buf_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] rem_q;
    logic             done_q;
    logic             irq_en_q;
    logic             src_fixed_q;
    logic             dst_fixed_q;

    logic busy;
    logic ctrl_wr;
    logic abort_req;
    logic start_req;
    logic start_go;
    logic rd_fire;
    logic wr_fire;

    assign busy      = (state != IDLE);
    assign ctrl_wr   = reg_wenable && (reg_addr == 2'd3);
    assign abort_req = ctrl_wr && reg_wdata[1];
    // Abort wins over start when both bits arrive in one write.
    assign start_req = ctrl_wr && reg_wdata[0] && !reg_wdata[1];
    assign start_go  = start_req && !busy;

    // A bus beat only happens when the CPU leaves the bus free and no abort
    // is arriving in the same cycle.
    assign rd_fire = (state == RD) && !cpu_busy && !abort_req;
    assign wr_fire = (state == WR) && !cpu_busy && !abort_req;

    // -------------------------------------------------------------------------
    // State register and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            buf_q       <= '0;
            len_q       <= '0;
            rem_q       <= '0;
            done_q      <= 1'b0;
            irq_en_q    <= 1'b0;
            src_fixed_q <= 1'b0;
            dst_fixed_q <= 1'b0;
        end else begin
            state <= state_nxt;

            // Programming registers are frozen while a transfer is in flight.
            if (reg_wenable && !busy) begin
                case (reg_addr)
                    2'd0: src_q <= {reg_wdata[31:2], 2'b00};
                    2'd1: dst_q <= {reg_wdata[31:2], 2'b00};
                    2'd2: len_q <= reg_wdata[LEN_W-1:0];
                    default: begin
                        src_fixed_q <= reg_wdata[3];
                        dst_fixed_q <= reg_wdata[4];
                    end
                endcase
            end

            if (ctrl_wr) begin
                irq_en_q <= reg_wdata[2];
            end

            if (start_go) begin
                done_q <= 1'b0;
                rem_q  <= len_q;
            end

            // Read data from the synchronous RAM is on the bus during CAP.
            if ((state == CAP) && !abort_req) begin
                buf_q <= m_rdata;
            end

            if (wr_fire) begin
                if (!src_fixed_q) begin
                    src_q <= src_q + 32'd4;
                end
                if (!dst_fixed_q) begin
                    dst_q <= dst_q + 32'd4;
                end
                rem_q <= rem_q - LEN_W'(1);
            end

            if ((state == DONE) && !abort_req) begin
                done_q <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_req) begin
                    state_nxt = (len_q != '0) ? RD : DONE;
                end
            end
            RD: begin
                if (rd_fire) begin
                    state_nxt = CAP;
                end
            end
            CAP: begin
                state_nxt = WR;
            end
            WR: begin
                if (wr_fire) begin
                    state_nxt = (rem_q == LEN_W'(1)) ? DONE : RD;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (busy && abort_req) begin
            state_nxt = IDLE;
        end
    end

    // -------------------------------------------------------------------------
    // Bus, interrupt and register read outputs
    // -------------------------------------------------------------------------
    always_comb begin
        m_req     = rd_fire || wr_fire;
        m_addr    = (state == RD) ? src_q : dst_q;
        m_wdata   = buf_q;
        m_wenable = wr_fire ? 4'hF : 4'h0;
        irq       = (state == DONE) && irq_en_q && !abort_req;
    end

    always_comb begin
        reg_rdata = 32'd0;
        case (reg_addr)
            2'd0: reg_rdata = src_q;
            2'd1: reg_rdata = dst_q;
            2'd2: reg_rdata = 32'(rem_q);
            default: begin
                reg_rdata = (32'(rem_q) << 16) |
                            {27'd0, dst_fixed_q, src_fixed_q, irq_en_q, done_q, busy};
            end
        endcase
    end

endmodule

// File: tb/tb_dma_engine.sv
// -----------------------------------------------------------------------------
// tb_dma_engine
//   Randomised and directed bench for dma_engine. A bench-side memory acts as
//   the synchronous RAM on the shared bus. For every transfer the bench lists
//   the reads and writes the copy must produce and the register state it must
//   end in; a monitor on the falling edge checks every bus beat against that
//   list and watches bus ownership and the interrupt.
// -----------------------------------------------------------------------------
module tb_dma_engine;

    localparam int LEN_W = 16;

    logic        clk;
    logic        rst_n;
    logic [1:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_wenable;
    logic [31:0] reg_rdata;
    logic        cpu_busy;
    logic        m_req;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wenable;
    logic [31:0] m_rdata;
    logic        irq;

    dma_engine #(.LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_wenable (reg_wenable),
        .reg_rdata   (reg_rdata),
        .cpu_busy    (cpu_busy),
        .m_req       (m_req),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_wenable   (m_wenable),
        .m_rdata     (m_rdata),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int irq_cnt = 0;
    int irq_cyc = 0;
    int start_cyc = 0;
    int wr_seen = 0;
    int bmode = 0;      // 0: bus free, 1: random cpu_busy, 2: toggle each cycle

    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_q [$];
    logic [31:0] wa_q [$];
    logic [31:0] wd_q [$];

    bit          pend;
    logic [31:0] pend_a;
    bit          irq_prev;

    // Initial RAM contents: a fixed scramble of the address.
    function automatic logic [31:0] f(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] memrd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return f(a);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Register access; called just after a rising edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        reg_addr    = a;
        reg_wdata   = d;
        reg_wenable = 1'b1;
        @(posedge clk); #1;
        reg_wenable = 1'b0;
    endtask

    task automatic chk_reg(input logic [1:0] a, input logic [31:0] exp, input string nm);
        reg_addr = a;
        #1;
        chk(nm, reg_rdata, exp);
    endtask

    task automatic wait_idle(input int max, input string nm);
        bit ok = 0;
        for (int i = 0; i < max; i++) begin
            reg_addr = 2'd3;
            #1;
            if (!reg_rdata[0]) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk({nm, "_finished"}, {31'd0, ok}, 32'd1);
    endtask

    // Complete transfer: program, list expected bus traffic, start, wait, check.
    task automatic do_xfer(input logic [31:0] src_w, input logic [31:0] dst_w, input int len,
                           input bit ie, input bit sf, input bit df, input int mode,
                           input string tag);
        logic [31:0] s;
        logic [31:0] d;
        logic [31:0] ra;
        int          ic;
        bmode = mode;
        wr(2'd0, src_w);
        wr(2'd1, dst_w);
        wr(2'd2, 32'(len));
        s = {src_w[31:2], 2'b00};
        d = {dst_w[31:2], 2'b00};
        for (int i = 0; i < len; i++) begin
            ra = s + (sf ? 32'd0 : 32'(4 * i));
            rd_q.push_back(ra);
            wa_q.push_back(d + (df ? 32'd0 : 32'(4 * i)));
            wd_q.push_back(f(ra));
        end
        ic = irq_cnt;
        wr(2'd3, {27'd0, df, sf, ie, 1'b0, 1'b1});
        wait_idle(800, tag);
        bmode = 0;
        chk({tag, "_reads_left"},  32'(rd_q.size()), 32'd0);
        chk({tag, "_writes_left"}, 32'(wa_q.size()), 32'd0);
        chk({tag, "_irq_count"},   32'(irq_cnt - ic), 32'(ie));
        if (ie && (mode == 0))
            chk({tag, "_latency"}, 32'(irq_cyc - start_cyc), 32'(3 * len + 1));
        chk_reg(2'd3, {27'd0, df, sf, ie, 1'b1, 1'b0}, {tag, "_status"});
        chk_reg(2'd0, s + (sf ? 32'd0 : 32'(4 * len)), {tag, "_src_end"});
        chk_reg(2'd1, d + (df ? 32'd0 : 32'(4 * len)), {tag, "_dst_end"});
        chk_reg(2'd2, 32'd0, {tag, "_remaining"});
    endtask

    // cpu_busy driver
    initial begin
        cpu_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (bmode)
                1:       cpu_busy = 1'($urandom % 2);
                2:       cpu_busy = ~cpu_busy;
                default: cpu_busy = 1'b0;
            endcase
        end
    end

    // Bus slave and monitor, on the falling edge.
    initial begin
        m_rdata  = '0;
        pend     = 0;
        pend_a   = '0;
        irq_prev = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (pend) m_rdata = memrd(pend_a);
            else      m_rdata = $urandom;
            pend = 0;
            if (!rst_n) begin
                irq_prev = 0;
            end else begin
                if (reg_wenable && reg_addr == 2'd3 && reg_wdata[0] && !reg_wdata[1])
                    start_cyc = cyc;
                if (m_req) begin
                    chk("bus_taken_while_cpu_busy", {31'd0, cpu_busy}, 32'd0);
                    if (m_wenable == 4'h0) begin
                        if (rd_q.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL unexpected_read: addr %h, no read required", m_addr);
                        end else begin
                            chk("read_addr", m_addr, rd_q.pop_front());
                        end
                        pend   = 1;
                        pend_a = m_addr;
                    end else if (m_wenable == 4'hF) begin
                        if (wa_q.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL unexpected_write: addr %h data %h, no write required",
                                     m_addr, m_wdata);
                        end else begin
                            chk("write_addr", m_addr, wa_q.pop_front());
                            chk("write_data", m_wdata, wd_q.pop_front());
                        end
                        mem[m_addr] = m_wdata;
                        wr_seen++;
                    end else begin
                        chk("m_wenable_value", 32'(m_wenable), 32'hF);
                    end
                end else if (m_wenable != 4'h0) begin
                    chk("m_wenable_without_req", 32'(m_wenable), 32'd0);
                end
                if (irq) begin
                    irq_cnt++;
                    irq_cyc = cyc;
                    chk("irq_single_cycle", {31'd0, irq_prev}, 32'd0);
                end
                irq_prev = irq;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: run did not finish, required finish");
        $fatal(1, "time limit reached");
    end

    // Main sequence
    initial begin
        int          ic;
        int          ws;
        logic [31:0] s;
        logic [31:0] d;
        int          len;
        bit          ie;
        bit          sf;
        bit          df;
        int          mode;

        rst_n       = 1'b0;
        reg_addr    = 2'd0;
        reg_wdata   = 32'd0;
        reg_wenable = 1'b0;
        #2;
        chk("rst_m_req", {31'd0, m_req}, 32'd0);
        chk("rst_m_wenable", 32'(m_wenable), 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_reg(2'd0, 32'd0, "rst_src");
        chk_reg(2'd1, 32'd0, "rst_dst");
        chk_reg(2'd2, 32'd0, "rst_remaining");
        chk_reg(2'd3, 32'd0, "rst_status");

        // Basic three-word copy with interrupt.
        do_xfer(32'h100, 32'h200, 3, 1, 0, 0, 0, "basic3");
        chk("basic3_irq_at_10", 32'(irq_cyc - start_cyc), 32'd10);
        chk_reg(2'd3, 32'h0000_0006, "basic3_status_literal");
        chk_reg(2'd0, 32'h0000_010C, "basic3_src_literal");
        chk("basic3_mem200_literal", memrd(32'h200), 32'h1334_A987);
        chk("basic3_mem208", memrd(32'h208), f(32'h108));

        // CPU takes the bus every other cycle.
        do_xfer(32'h300, 32'h400, 2, 1, 0, 0, 2, "toggle2");
        chk("toggle2_not_early", {31'd0, (irq_cyc - start_cyc) >= 7}, 32'd1);
        chk("toggle2_mem404", memrd(32'h404), f(32'h304));

        // Zero-length start.
        do_xfer(32'h1000, 32'h8000_0000, 0, 1, 0, 0, 0, "len0");
        chk("len0_latency_literal", 32'(irq_cyc - start_cyc), 32'd1);

        // Fixed destination, no interrupt.
        do_xfer(32'h500, 32'hE000_0000, 4, 0, 0, 1, 0, "dstfix");
        chk_reg(2'd0, 32'h0000_0510, "dstfix_src_literal");
        chk("dstfix_mem_literal", memrd(32'hE000_0000), 32'h1738_A987);

        // Abort after two of five words; writes while busy must be ignored.
        bmode = 0;
        wr(2'd0, 32'h600);
        wr(2'd1, 32'h700);
        wr(2'd2, 32'd5);
        for (int i = 0; i < 2; i++) begin
            rd_q.push_back(32'h600 + 32'(4 * i));
            wa_q.push_back(32'h700 + 32'(4 * i));
            wd_q.push_back(f(32'h600 + 32'(4 * i)));
        end
        ic = irq_cnt;
        ws = wr_seen;
        wr(2'd3, 32'h5);
        wr(2'd0, 32'h000D_EAD0);
        wr(2'd2, 32'd9);
        for (int i = 0; i < 100; i++) begin
            if (wr_seen - ws >= 2) break;
            @(posedge clk); #1;
        end
        chk("abort_two_words_written", 32'(wr_seen - ws), 32'd2);
        wr(2'd3, 32'h6);
        repeat (6) @(posedge clk);
        #1;
        chk_reg(2'd3, 32'h0003_0004, "abort_status");
        chk_reg(2'd0, 32'h0000_0608, "abort_src");
        chk_reg(2'd1, 32'h0000_0708, "abort_dst");
        chk_reg(2'd2, 32'd3, "abort_remaining");
        chk("abort_no_irq", 32'(irq_cnt - ic), 32'd0);
        chk("abort_reads_left", 32'(rd_q.size()), 32'd0);
        chk("abort_writes_left", 32'(wa_q.size()), 32'd0);

        // Reset asserted while the first write is on the bus.
        @(posedge clk); #1;
        wr(2'd0, 32'h800);
        wr(2'd1, 32'h900);
        wr(2'd2, 32'd3);
        rd_q.push_back(32'h800);
        wr(2'd3, 32'h1D);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rstwr_m_req", {31'd0, m_req}, 32'd1);
        chk("rstwr_m_wenable", 32'(m_wenable), 32'hF);
        chk("rstwr_m_addr", m_addr, 32'h900);
        chk("rstwr_m_wdata", m_wdata, f(32'h800));
        #1 rst_n = 1'b0;
        #1;
        chk("rstwr_m_req_cleared", {31'd0, m_req}, 32'd0);
        chk("rstwr_m_wenable_cleared", 32'(m_wenable), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        #1;
        chk_reg(2'd3, 32'd0, "rstwr_status");
        chk_reg(2'd0, 32'd0, "rstwr_src");
        chk_reg(2'd1, 32'd0, "rstwr_dst");
        chk("rstwr_reads_left", 32'(rd_q.size()), 32'd0);
        chk("rstwr_writes_left", 32'(wa_q.size()), 32'd0);
        @(posedge clk); #1;

        // Randomised transfers; every fifth destination wraps past 2^32.
        for (int t = 0; t < 20; t++) begin
            s    = 32'h0000_1000 | ($urandom & 32'h0000_0FFC) | 32'($urandom_range(0, 3));
            d    = (t % 5 == 4) ? 32'hFFFF_FFF8
                                : (32'h8000_0000 | ($urandom & 32'h0000_FFFC));
            d    = d | 32'($urandom_range(0, 3));
            len  = $urandom_range(0, 6);
            ie   = 1'($urandom % 2);
            sf   = 1'($urandom % 2);
            df   = 1'($urandom % 2);
            mode = $urandom_range(0, 1);
            do_xfer(s, d, len, ie, sf, df, mode, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
